digit_scroller: RTL and testbench

DIGIT_SCROLLER -- requirements
Module: digit_scroller

---
 rtl/digit_scroller_pkg.sv | 31 +++
 rtl/digit_fifo.sv | 54 +++++
 rtl/digit_scroller.sv | 114 +++++++++++
 tb/tb_digit_scroller.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scroller_pkg.sv
// Shared constants and types for the digit scroller and the seven-segment decoder.
package digit_scroller_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] window_t;

    localparam digit_t BLANK_CODE = 4'hF;

    // Active-low segments in gfedcba order; anything outside 0..9 (including BLANK_CODE) goes dark.
    function automatic logic [6:0] sevenSegDecode(input digit_t i_digit);
        logic [6:0] segs;
        case (i_digit)
            4'd0:    segs = 7'b1000000;
            4'd1:    segs = 7'b1111001;
            4'd2:    segs = 7'b0100100;
            4'd3:    segs = 7'b0110000;
            4'd4:    segs = 7'b0011001;
            4'd5:    segs = 7'b0010010;
            4'd6:    segs = 7'b0000010;
            4'd7:    segs = 7'b1111000;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0010000;
            default: segs = 7'b1111111;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/digit_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module digit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == COUNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rdPtr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/digit_scroller.sv
// Six-digit scrolling display window fed from a small digit FIFO, one shift per prescaler tick.
// Define BLANK_LEADING_EN to show not-yet-filled positions as BLANK_CODE instead of 0.
module digit_scroller
    import digit_scroller_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLOCK_50,
    input  logic               KEY0,
    input  logic [DIGIT_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               pause_n,
    output logic [DIGIT_W-1:0] dig0,
    output logic [DIGIT_W-1:0] dig1,
    output logic [DIGIT_W-1:0] dig2,
    output logic [DIGIT_W-1:0] dig3,
    output logic [DIGIT_W-1:0] dig4,
    output logic [DIGIT_W-1:0] dig5,
    output logic               scroll_pulse
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

`ifdef BLANK_LEADING_EN
    localparam digit_t UNFILLED_CODE = BLANK_CODE;
`else
    localparam digit_t UNFILLED_CODE = '0;
`endif

    logic [CNT_W-1:0]      r_prescale;
    logic                  r_pauseMeta;
    logic                  r_pauseSync;
    window_t               r_window;
    logic [NUM_DIGITS-1:0] r_occ;

    logic    w_tick;
    logic    w_tickEn;
    logic    w_push;
    logic    w_pop;
    logic    w_fifoFull;
    logic    w_fifoEmpty;
    digit_t  w_fifoHead;
    window_t w_display;

    assign w_tick   = (r_prescale == CNT_LAST);
    assign w_tickEn = w_tick && r_pauseSync;
    assign w_push   = din_valid && din_ready;
    assign w_pop    = w_tickEn && !w_fifoEmpty;

    assign din_ready    = !w_fifoFull;
    assign scroll_pulse = w_pop;

    // Free-running prescaler; pausing only masks its ticks.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_pauseMeta <= 1'b1;
            r_pauseSync <= 1'b1;
        end else begin
            r_pauseMeta <= pause_n;
            r_pauseSync <= r_pauseMeta;
        end
    end

    digit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DIGIT_W)
    ) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst_n (KEY0),
        .i_push  (w_push),
        .i_data  (din),
        .i_pop   (w_pop),
        .o_data  (w_fifoHead),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // The popped head enters at position 0 and everything moves one place left.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_window <= '0;
            r_occ    <= '0;
        end else if (w_pop) begin
            r_window <= {r_window[NUM_DIGITS-2:0], w_fifoHead};
            r_occ    <= {r_occ[NUM_DIGITS-2:0], 1'b1};
        end
    end

    always_comb begin
        w_display = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_display[i] = r_occ[i] ? r_window[i] : UNFILLED_CODE;
        end
    end

    assign dig0 = w_display[0];
    assign dig1 = w_display[1];
    assign dig2 = w_display[2];
    assign dig3 = w_display[3];
    assign dig4 = w_display[4];
    assign dig5 = w_display[5];

endmodule

// File: tb/tb_digit_scroller.sv
// Self-checking bench for digit_scroller using a queue scoreboard and a cycle model.
// Expectations follow BLANK_LEADING_EN when it is defined for the build.
module tb_digit_scroller;

    localparam int TICK_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM        = 6;

`ifdef BLANK_LEADING_EN
    localparam logic [3:0] UNF = 4'hF;
`else
    localparam logic [3:0] UNF = 4'h0;
`endif

    logic       CLOCK_50;
    logic       KEY0;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       pause_n;
    logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5;
    logic       scroll_pulse;
    logic [3:0] digOut [NUM];

    assign digOut[0] = dig0;
    assign digOut[1] = dig1;
    assign digOut[2] = dig2;
    assign digOut[3] = dig3;
    assign digOut[4] = dig4;
    assign digOut[5] = dig5;

    digit_scroller #(
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .KEY0         (KEY0),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .pause_n      (pause_n),
        .dig0         (dig0),
        .dig1         (dig1),
        .dig2         (dig2),
        .dig3         (dig3),
        .dig4         (dig4),
        .dig5         (dig5),
        .scroll_pulse (scroll_pulse)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Scoreboard queue holds accepted digits not yet shifted into the window.
    logic [3:0] mQ [$];
    logic [3:0] mWin [NUM];
    logic       mOcc [NUM];
    int         mCnt;
    logic       mSync1;
    logic       mSync2;
    int         cycleNum;
    int         nCompared;
    int         nMismatched;

    function automatic logic [3:0] expDig(input int i);
        return mOcc[i] ? mWin[i] : UNF;
    endfunction

    function automatic logic expPulse();
        return (mCnt == TICK_DIV - 1) && mSync2 && (mQ.size() > 0);
    endfunction

    function automatic logic expReady();
        return mQ.size() < FIFO_DEPTH;
    endfunction

    task automatic modelReset();
        mQ.delete();
        for (int i = 0; i < NUM; i++) begin
            mWin[i] = 4'h0;
            mOcc[i] = 1'b0;
        end
        mCnt   = 0;
        mSync1 = 1'b1;
        mSync2 = 1'b1;
    endtask

    // Advance one clock; called at posedge+1 and returns at the next posedge+1.
    task automatic step();
        logic doPush;
        logic doPop;
        doPush = din_valid && (mQ.size() < FIFO_DEPTH);
        doPop  = expPulse();
        @(posedge CLOCK_50);
        #1;
        if (doPop) begin
            for (int i = NUM - 1; i > 0; i--) begin
                mWin[i] = mWin[i-1];
                mOcc[i] = mOcc[i-1];
            end
            mWin[0] = mQ.pop_front();
            mOcc[0] = 1'b1;
        end
        if (doPush) mQ.push_back(din);
        mCnt   = (mCnt == TICK_DIV - 1) ? 0 : mCnt + 1;
        mSync2 = mSync1;
        mSync1 = pause_n;
        cycleNum++;
    endtask

    task automatic test_reset();
        din_valid = 1'b0;
        pause_n   = 1'b1;
        KEY0      = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== UNF) begin
                nMismatched++;
                $display("[TB] FAIL reset_dig%0d: got %h, expected %h", i, digOut[i], UNF);
            end
        end
        nCompared++;
        if (din_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_din_ready: got %b, expected 1", din_ready);
        end
        nCompared++;
        if (scroll_pulse !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_scroll_pulse: got %b, expected 0", scroll_pulse);
        end
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        KEY0 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [4];
        logic [3:0] expWin [NUM];
        logic [3:0] expHead;
        int pulses;
        int lastPulse;
        vals      = '{4'd2, 4'd7, 4'd1, 4'd8};
        expWin    = '{4'd8, 4'd1, 4'd7, 4'd2, UNF, UNF};
        pulses    = 0;
        lastPulse = -1;
        for (int k = 0; k < 40 && pulses < 4; k++) begin
            if (k < 4) begin
                din       = vals[k];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            nCompared++;
            if (scroll_pulse !== expPulse()) begin
                nMismatched++;
                $display("[TB] FAIL b2b_pulse cycle %0d: got %b, expected %b", cycleNum, scroll_pulse, expPulse());
            end
            if (scroll_pulse === 1'b1) begin
                pulses++;
                if (lastPulse >= 0) begin
                    nCompared++;
                    if (cycleNum - lastPulse !== TICK_DIV) begin
                        nMismatched++;
                        $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", cycleNum - lastPulse, TICK_DIV);
                    end
                end
                lastPulse = cycleNum;
                expHead   = (mQ.size() > 0) ? mQ[0] : UNF;
                step();
                nCompared++;
                if (dig0 !== expHead) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_head: got %h, expected %h", dig0, expHead);
                end
            end else begin
                step();
            end
        end
        din_valid = 1'b0;
        nCompared++;
        if (pulses != 4) begin
            nMismatched++;
            $display("[TB] FAIL b2b_pulse_count: got %0d, expected 4", pulses);
        end
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== expWin[i]) begin
                nMismatched++;
                $display("[TB] FAIL b2b_dig%0d: got %h, expected %h", i, digOut[i], expWin[i]);
            end
        end
    endtask

    task automatic test_empty();
        din_valid = 1'b0;
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            nCompared++;
            if (scroll_pulse !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL empty_pulse cycle %0d: got %b, expected 0", cycleNum, scroll_pulse);
            end
            step();
        end
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== expDig(i)) begin
                nMismatched++;
                $display("[TB] FAIL empty_dig%0d: got %h, expected %h", i, digOut[i], expDig(i));
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] vals [4];
        logic [3:0] expWin [NUM];
        int relCycle;
        int pulseCycle;
        logic found;
        vals   = '{4'd3, 4'd1, 4'd4, 4'd1};
        expWin = '{4'd5, 4'd1, 4'd4, 4'd1, 4'd3, 4'd8};
        din_valid = 1'b0;
        pause_n   = 1'b0;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 4; k++) begin
            din       = vals[k];
            din_valid = 1'b1;
            step();
        end
        din = 4'd5;
        nCompared++;
        if (din_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL pause_full_ready: got %b, expected 0", din_ready);
        end
        for (int k = 0; k < 20; k++) begin
            nCompared++;
            if (scroll_pulse !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL pause_pulse cycle %0d: got %b, expected 0", cycleNum, scroll_pulse);
            end
            step();
        end
        pause_n    = 1'b1;
        relCycle   = cycleNum;
        pulseCycle = -1;
        found      = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            nCompared++;
            if (scroll_pulse !== expPulse()) begin
                nMismatched++;
                $display("[TB] FAIL release_pulse cycle %0d: got %b, expected %b", cycleNum, scroll_pulse, expPulse());
            end
            if (scroll_pulse === 1'b1) begin
                found      = 1'b1;
                pulseCycle = cycleNum;
            end else begin
                step();
            end
        end
        nCompared++;
        if (!found) begin
            nMismatched++;
            $display("[TB] FAIL release_timeout: got no pulse, expected one within 20 cycles");
        end else begin
            nCompared++;
            if (pulseCycle - relCycle < 2) begin
                nMismatched++;
                $display("[TB] FAIL release_latency: got %0d, expected >= 2", pulseCycle - relCycle);
            end
        end
        nCompared++;
        if (din_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_pop_ready: got %b, expected 0", din_ready);
        end
        step();
        nCompared++;
        if (din_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ready_rise: got %b, expected 1", din_ready);
        end
        step();
        din_valid = 1'b0;
        nCompared++;
        if (din_ready !== expReady()) begin
            nMismatched++;
            $display("[TB] FAIL fifth_accept_ready: got %b, expected %b", din_ready, expReady());
        end
        for (int k = 0; k < 40 && mQ.size() > 0; k++) step();
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== expWin[i]) begin
                nMismatched++;
                $display("[TB] FAIL pause_dig%0d: got %h, expected %h", i, digOut[i], expWin[i]);
            end
        end
    endtask

    task automatic test_non_bcd();
        logic [3:0] vals [6];
        logic [3:0] expWin [NUM];
        int idx;
        logic accept;
        vals   = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        expWin = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        idx    = 0;
        for (int k = 0; k < 80 && (idx < 6 || mQ.size() > 0); k++) begin
            if (idx < 6) begin
                din       = vals[idx];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            nCompared++;
            if (scroll_pulse !== expPulse()) begin
                nMismatched++;
                $display("[TB] FAIL nbcd_pulse cycle %0d: got %b, expected %b", cycleNum, scroll_pulse, expPulse());
            end
            nCompared++;
            if (din_ready !== expReady()) begin
                nMismatched++;
                $display("[TB] FAIL nbcd_ready cycle %0d: got %b, expected %b", cycleNum, din_ready, expReady());
            end
            accept = expReady() && (idx < 6);
            step();
            if (accept) idx++;
        end
        din_valid = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== expWin[i]) begin
                nMismatched++;
                $display("[TB] FAIL nbcd_dig%0d: got %h, expected %h", i, digOut[i], expWin[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] vals [4];
        int idx;
        logic accept;
        vals = '{4'd9, 4'd8, 4'd7, 4'd6};
        idx  = 0;
        for (int k = 0; k < 30 && !(idx == 4 && mQ.size() == 3); k++) begin
            if (idx < 4) begin
                din       = vals[idx];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            accept = expReady() && (idx < 4);
            step();
            if (accept) idx++;
        end
        din_valid = 1'b0;
        nCompared++;
        if (dig0 !== expDig(0)) begin
            nMismatched++;
            $display("[TB] FAIL mid_pre_dig0: got %h, expected %h", dig0, expDig(0));
        end
        #2;
        KEY0 = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== UNF) begin
                nMismatched++;
                $display("[TB] FAIL mid_reset_dig%0d: got %h, expected %h", i, digOut[i], UNF);
            end
        end
        nCompared++;
        if (din_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_ready: got %b, expected 1", din_ready);
        end
        nCompared++;
        if (scroll_pulse !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_pulse: got %b, expected 0", scroll_pulse);
        end
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        KEY0 = 1'b1;
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            nCompared++;
            if (scroll_pulse !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL stale_pulse cycle %0d: got %b, expected 0", cycleNum, scroll_pulse);
            end
            step();
        end
        for (int i = 0; i < NUM; i++) begin
            nCompared++;
            if (digOut[i] !== UNF) begin
                nMismatched++;
                $display("[TB] FAIL stale_dig%0d: got %h, expected %h", i, digOut[i], UNF);
            end
        end
        nCompared++;
        if (din_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL stale_ready: got %b, expected 1", din_ready);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        cycleNum    = 0;
        KEY0        = 1'b1;
        pause_n     = 1'b1;
        din         = 4'h0;
        din_valid   = 1'b0;
        modelReset();
        #2;
        $display("[TB] starting digit_scroller bench");
        test_reset();
        test_back_to_back();
        test_empty();
        test_pause();
        test_non_bcd();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
